// File: rtl/muldiv_iter_if.sv
// Bus bundle for the iterative multiply/divide unit: request side, result side
// and a debug view of the controller state.
//
// Handshake: a request (start plus op/a/b) is accepted on a rising clk edge only
// while busy is low and flush is low. Requests offered while busy is high are
// dropped, not queued. For ops 0-3 busy rises at the accepting edge. done is a
// one-cycle pulse in the cycle after the result is written to hi/lo, and busy is
// already low in that cycle. Ops 4/5 write hi/lo at the accepting edge and never
// raise busy or done.
interface muldiv_iter_if #(
   parameter int WIDTH = 32
);
   logic             start;
   logic [2:0]       op;
   logic [WIDTH-1:0] a;
   logic [WIDTH-1:0] b;
   logic             flush;
   logic             busy;
   logic             done;
   logic             dbz;
   logic [WIDTH-1:0] hi;
   logic [WIDTH-1:0] lo;
   logic [1:0]       dbg_state;

   modport master (
      output start, op, a, b, flush,
      input  busy, done, dbz, hi, lo, dbg_state
   );

   modport slave (
      input  start, op, a, b, flush,
      output busy, done, dbz, hi, lo, dbg_state
   );
endinterface

// File: rtl/muldiv_iter.sv
// Iterative MULT/MULTU/DIV/DIVU unit with its own HI/LO registers.
// One shift-add / restoring shift-subtract datapath works on operand magnitudes;
// signs are applied in a single fix-up cycle at the end.
module muldiv_iter #(
   parameter int WIDTH = 32,
   parameter int CNT_W = $clog2(WIDTH) + 1
) (
   input logic          clk,
   input logic          reset,
   muldiv_iter_if.slave bus
);
   typedef enum logic [1:0] {IDLE = 2'd0, RUN = 2'd1, FIX = 2'd2} state_t;

   state_t             state;
   state_t             state_nx;
   logic [CNT_W-1:0]   cnt;
   logic [WIDTH-1:0]   acc_hi;    // product high half / partial remainder
   logic [WIDTH-1:0]   acc_lo;    // multiplier bits / dividend-then-quotient
   logic [WIDTH-1:0]   dvs;       // multiplicand or divisor magnitude
   logic               is_div;
   logic               neg_res;
   logic               neg_rem;
   logic               div_zero;
   logic [WIDTH-1:0]   hi_q;
   logic [WIDTH-1:0]   lo_q;
   logic               done_q;
   logic               dbz_q;

   logic               accept;
   logic               md_start;
   logic               sgn_op;
   logic               a_neg;
   logic               b_neg;
   logic [WIDTH-1:0]   a_mag;
   logic [WIDTH-1:0]   b_mag;
   logic [WIDTH:0]     mul_sum;
   logic [WIDTH:0]     div_sh;
   logic [WIDTH-1:0]   div_diff;
   logic               div_ge;
   logic [2*WIDTH-1:0] prod_fix;
   logic [WIDTH-1:0]   quo_fix;
   logic [WIDTH-1:0]   rem_fix;

   // Request decode and operand magnitudes; flush in IDLE suppresses any start.
   always_comb begin
      accept   = (state == IDLE) && bus.start && !bus.flush;
      md_start = accept && !bus.op[2];
      sgn_op   = ~bus.op[0];
      a_neg    = sgn_op & bus.a[WIDTH-1];
      b_neg    = sgn_op & bus.b[WIDTH-1];
      a_mag    = a_neg ? -bus.a : bus.a;
      b_mag    = b_neg ? -bus.b : bus.b;
   end

   // One iteration step of each algorithm plus the final sign fix-up.
   // The remainder stays below the divisor, so the W-bit difference is exact.
   always_comb begin
      mul_sum  = {1'b0, acc_hi} + (acc_lo[0] ? {1'b0, dvs} : '0);
      div_sh   = {acc_hi, acc_lo[WIDTH-1]};
      div_ge   = div_sh >= {1'b0, dvs};
      div_diff = div_sh[WIDTH-1:0] - dvs;
      prod_fix = neg_res ? -{acc_hi, acc_lo} : {acc_hi, acc_lo};
      quo_fix  = div_zero ? '1 : (neg_res ? -acc_lo : acc_lo);
      rem_fix  = neg_rem ? -acc_hi : acc_hi;
   end

   // Controller state register.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) state <= IDLE;
      else        state <= state_nx;
   end

   // Next-state logic: flush returns to IDLE from RUN or FIX.
   always_comb begin
      state_nx = state;
      case (state)
         IDLE:    if (md_start) state_nx = RUN;
         RUN:     if (bus.flush) state_nx = IDLE;
                  else if (cnt == CNT_W'(1)) state_nx = FIX;
         FIX:     state_nx = IDLE;
         default: state_nx = IDLE;
      endcase
   end

   // Operand latch, iteration datapath and HI/LO/flag registers.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         cnt      <= '0;
         acc_hi   <= '0;
         acc_lo   <= '0;
         dvs      <= '0;
         is_div   <= 1'b0;
         neg_res  <= 1'b0;
         neg_rem  <= 1'b0;
         div_zero <= 1'b0;
         hi_q     <= '0;
         lo_q     <= '0;
         done_q   <= 1'b0;
         dbz_q    <= 1'b0;
      end else begin
         done_q <= 1'b0;
         case (state)
            IDLE: begin
               if (md_start) begin
                  acc_hi   <= '0;
                  acc_lo   <= bus.op[1] ? a_mag : b_mag;
                  dvs      <= bus.op[1] ? b_mag : a_mag;
                  is_div   <= bus.op[1];
                  neg_res  <= a_neg ^ b_neg;
                  neg_rem  <= a_neg;
                  div_zero <= bus.op[1] && (bus.b == '0);
                  dbz_q    <= 1'b0;
                  cnt      <= CNT_W'(WIDTH);
               end else if (accept && bus.op == 3'd4) begin
                  hi_q <= bus.a;
               end else if (accept && bus.op == 3'd5) begin
                  lo_q <= bus.a;
               end
            end
            RUN: begin
               if (!bus.flush) begin
                  cnt <= cnt - CNT_W'(1);
                  if (is_div) begin
                     acc_hi <= div_ge ? div_diff : div_sh[WIDTH-1:0];
                     acc_lo <= {acc_lo[WIDTH-2:0], div_ge};
                  end else begin
                     acc_hi <= mul_sum[WIDTH:1];
                     acc_lo <= {mul_sum[0], acc_lo[WIDTH-1:1]};
                  end
               end
            end
            FIX: begin
               if (!bus.flush) begin
                  hi_q   <= is_div ? rem_fix : prod_fix[2*WIDTH-1:WIDTH];
                  lo_q   <= is_div ? quo_fix : prod_fix[WIDTH-1:0];
                  done_q <= 1'b1;
                  dbz_q  <= div_zero;
               end
            end
            default: ;
         endcase
      end
   end

   assign bus.busy      = (state != IDLE);
   assign bus.done      = done_q;
   assign bus.dbz       = dbz_q;
   assign bus.hi        = hi_q;
   assign bus.lo        = lo_q;
   assign bus.dbg_state = state;
endmodule

// File: tb/tb_muldiv_iter.sv
// Bench for muldiv_iter: a 32-bit instance driven through a scoreboard fed by a
// reference model, plus an 8-bit instance for narrow-width corner cases.
module tb_muldiv_iter;
   localparam int W = 32;

   logic clk = 1'b0;
   logic reset;
   always #5 clk = ~clk;

   muldiv_iter_if #(.WIDTH(W)) bus ();
   muldiv_iter_if #(.WIDTH(8)) bus8 ();

   muldiv_iter #(.WIDTH(W)) dut (.clk(clk), .reset(reset), .bus(bus));
   muldiv_iter #(.WIDTH(8)) dut8 (.clk(clk), .reset(reset), .bus(bus8));

   int n_checks = 0;
   int n_pass   = 0;
   logic [2*W:0] exp_q[$];   // {dbz, hi, lo}

   // Reference model: {dbz, hi, lo} for ops 0-3.
   function automatic logic [2*W:0] model(input logic [2:0] op, input logic [W-1:0] a, input logic [W-1:0] b);
      logic signed [2*W-1:0] sa, sb, sq, sr;
      logic [2*W-1:0] up;
      sa = {{W{a[W-1]}}, a};
      sb = {{W{b[W-1]}}, b};
      case (op)
         3'd0: begin up = sa * sb; return {1'b0, up}; end
         3'd1: begin up = {{W{1'b0}}, a} * {{W{1'b0}}, b}; return {1'b0, up}; end
         3'd2: begin
            if (b == '0) return {1'b1, a, {W{1'b1}}};
            sq = sa / sb;
            sr = sa % sb;
            return {1'b0, sr[W-1:0], sq[W-1:0]};
         end
         3'd3: begin
            if (b == '0) return {1'b1, a, {W{1'b1}}};
            return {1'b0, a % b, a / b};
         end
         default: return '0;
      endcase
   endfunction

   // Driver: offer one mul/div request, record its expected result, return just
   // after the accepting edge with start low.
   task automatic start_op(input logic [2:0] op, input logic [W-1:0] a, input logic [W-1:0] b);
      exp_q.push_back(model(op, a, b));
      bus.op    = op;
      bus.a     = a;
      bus.b     = b;
      bus.start = 1'b1;
      @(posedge clk); #1;
      bus.start = 1'b0;
   endtask

   // Wait for done (bounded). lat = edges until done seen (-1 on timeout),
   // bcnt = cycles busy was seen high, counting the sample taken on entry.
   task automatic wait_done(input int max, output int lat, output int bcnt);
      lat  = -1;
      bcnt = bus.busy ? 1 : 0;
      for (int k = 1; k <= max; k++) begin
         @(posedge clk); #1;
         if (bus.done) begin
            lat = k;
            break;
         end
         if (bus.busy) bcnt++;
      end
   endtask

   task automatic test_reset();
      bus.start = 0; bus.op = 0; bus.a = 0; bus.b = 0; bus.flush = 0;
      bus8.start = 0; bus8.op = 0; bus8.a = 0; bus8.b = 0; bus8.flush = 0;
      reset = 1'b0;
      #1;
      n_checks++;
      if ({bus.busy, bus.done, bus.dbz} !== 3'b000) $display("FAIL reset_flags: got %b want 000", {bus.busy, bus.done, bus.dbz});
      else n_pass++;
      n_checks++;
      if ({bus.hi, bus.lo} !== '0) $display("FAIL reset_hilo: got %h want 0", {bus.hi, bus.lo});
      else n_pass++;
      n_checks++;
      if ({bus8.hi, bus8.lo, bus8.busy} !== '0) $display("FAIL reset_w8: got %h want 0", {bus8.hi, bus8.lo, bus8.busy});
      else n_pass++;
      @(posedge clk); #1;
      reset = 1'b1;
      @(posedge clk); #1;
   endtask

   task automatic test_arith();
      logic [2:0]   t_op[7];
      logic [W-1:0] t_a[7], t_b[7], t_hi[7], t_lo[7];
      logic         t_dbz[7];
      logic [2*W:0] exp;
      int lat, bcnt;
      t_op  = '{3'd1, 3'd0, 3'd2, 3'd3, 3'd2, 3'd3, 3'd1};
      t_a   = '{32'hFFFFFFFF, 32'hFFFFFFF9, 32'hFFFFFFF9, 32'd7, 32'h80000000, 32'h1234, 32'd5};
      t_b   = '{32'hFFFFFFFF, 32'd3, 32'd2, 32'd2, 32'hFFFFFFFF, 32'd0, 32'd6};
      t_hi  = '{32'hFFFFFFFE, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'd1, 32'd0, 32'h1234, 32'd0};
      t_lo  = '{32'h00000001, 32'hFFFFFFEB, 32'hFFFFFFFD, 32'd3, 32'h80000000, 32'hFFFFFFFF, 32'd30};
      t_dbz = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0};
      for (int i = 0; i < 7; i++) begin
         start_op(t_op[i], t_a[i], t_b[i]);
         if (i == 6) begin
            n_checks++;
            if (bus.dbz !== 1'b0) $display("FAIL dbz_clear_on_start: got %b want 0", bus.dbz);
            else n_pass++;
         end
         wait_done(40, lat, bcnt);
         n_checks++;
         if (lat !== W + 1) $display("FAIL arith_latency[%0d]: got %0d want %0d", i, lat, W + 1);
         else n_pass++;
         n_checks++;
         if (bcnt !== W + 1 || bus.busy !== 1'b0) $display("FAIL arith_busy[%0d]: got %0d cycles busy_at_done=%b want %0d and 0", i, bcnt, bus.busy, W + 1);
         else n_pass++;
         exp = exp_q.pop_front();
         n_checks++;
         if ({bus.dbz, bus.hi, bus.lo} !== exp) $display("FAIL arith_scoreboard[%0d]: got %h want %h", i, {bus.dbz, bus.hi, bus.lo}, exp);
         else n_pass++;
         n_checks++;
         if ({bus.dbz, bus.hi, bus.lo} !== {t_dbz[i], t_hi[i], t_lo[i]}) $display("FAIL arith_table[%0d]: got %h want %h", i, {bus.dbz, bus.hi, bus.lo}, {t_dbz[i], t_hi[i], t_lo[i]});
         else n_pass++;
      end
      @(posedge clk); #1;
      n_checks++;
      if (bus.done !== 1'b0) $display("FAIL done_one_cycle: got %b want 0", bus.done);
      else n_pass++;
   endtask

   task automatic test_mthi_mtlo();
      bus.op = 3'd4; bus.a = 32'hA5A5A5A5; bus.start = 1'b1;
      @(posedge clk); #1;
      n_checks++;
      if ({bus.hi, bus.busy, bus.done} !== {32'hA5A5A5A5, 2'b00}) $display("FAIL mthi: got hi=%h busy=%b done=%b want a5a5a5a5 0 0", bus.hi, bus.busy, bus.done);
      else n_pass++;
      bus.op = 3'd5; bus.a = 32'h5A5A5A5A;
      @(posedge clk); #1;
      n_checks++;
      if ({bus.hi, bus.lo, bus.busy, bus.done} !== {32'hA5A5A5A5, 32'h5A5A5A5A, 2'b00}) $display("FAIL mtlo: got hi=%h lo=%h busy=%b done=%b", bus.hi, bus.lo, bus.busy, bus.done);
      else n_pass++;
      // start together with flush in IDLE must be dropped
      bus.op = 3'd4; bus.a = 32'hDEADBEEF; bus.flush = 1'b1;
      @(posedge clk); #1;
      bus.start = 1'b0; bus.flush = 1'b0;
      n_checks++;
      if ({bus.hi, bus.busy} !== {32'hA5A5A5A5, 1'b0}) $display("FAIL flush_idle_start: got hi=%h busy=%b want a5a5a5a5 0", bus.hi, bus.busy);
      else n_pass++;
      // no-op codes leave everything alone
      bus.op = 3'd6; bus.a = 32'h0BADF00D; bus.start = 1'b1;
      @(posedge clk); #1;
      bus.op = 3'd7;
      @(posedge clk); #1;
      bus.start = 1'b0;
      n_checks++;
      if ({bus.hi, bus.lo, bus.busy} !== {32'hA5A5A5A5, 32'h5A5A5A5A, 1'b0}) $display("FAIL noop_ops: got hi=%h lo=%h busy=%b", bus.hi, bus.lo, bus.busy);
      else n_pass++;
   endtask

   task automatic test_busy_ignore();
      logic [2*W:0] exp;
      int lat, bcnt;
      start_op(3'd1, 32'h12345678, 32'h9ABCDEF0);
      repeat (4) begin @(posedge clk); #1; end
      bus.op = 3'd3; bus.a = 32'd100; bus.b = 32'd3; bus.start = 1'b1;
      @(posedge clk); #1;
      bus.op = 3'd4; bus.a = 32'hFFFF0000;
      @(posedge clk); #1;
      bus.start = 1'b0; bus.a = $urandom; bus.b = $urandom;
      wait_done(40, lat, bcnt);
      n_checks++;
      if (lat !== W + 1 - 6) $display("FAIL busy_ignore_latency: got %0d want %0d", lat, W + 1 - 6);
      else n_pass++;
      exp = exp_q.pop_front();
      n_checks++;
      if ({bus.dbz, bus.hi, bus.lo} !== exp) $display("FAIL busy_ignore_result: got %h want %h", {bus.dbz, bus.hi, bus.lo}, exp);
      else n_pass++;
      @(posedge clk); #1;
      n_checks++;
      if (bus.busy !== 1'b0) $display("FAIL busy_ignore_no_queue: got busy=%b want 0", bus.busy);
      else n_pass++;
   endtask

   task automatic test_flush();
      int seen;
      bus.op = 3'd4; bus.a = 32'h11112222; bus.start = 1'b1;
      @(posedge clk); #1;
      bus.op = 3'd5; bus.a = 32'h33334444;
      @(posedge clk); #1;
      // flush during RUN
      bus.op = 3'd2; bus.a = 32'd100; bus.b = 32'd7;
      @(posedge clk); #1;
      bus.start = 1'b0;
      repeat (9) begin @(posedge clk); #1; end
      bus.flush = 1'b1;
      @(posedge clk); #1;
      bus.flush = 1'b0;
      n_checks++;
      if ({bus.busy, bus.dbg_state} !== 3'b000) $display("FAIL flush_run_idle: got busy=%b state=%0d want 0 0", bus.busy, bus.dbg_state);
      else n_pass++;
      seen = 0;
      repeat (40) begin @(posedge clk); #1; if (bus.done) seen++; end
      n_checks++;
      if ({seen, bus.hi, bus.lo, bus.dbz} !== {32'd0, 32'h11112222, 32'h33334444, 1'b0}) $display("FAIL flush_run_keep: got done_count=%0d hi=%h lo=%h dbz=%b", seen, bus.hi, bus.lo, bus.dbz);
      else n_pass++;
      // flush during FIX
      bus.op = 3'd3; bus.a = 32'd50; bus.b = 32'd0; bus.start = 1'b1;
      @(posedge clk); #1;
      bus.start = 1'b0;
      repeat (W) begin @(posedge clk); #1; end
      n_checks++;
      if ({bus.busy, bus.dbg_state} !== 3'b110) $display("FAIL fix_reached: got busy=%b state=%0d want 1 2", bus.busy, bus.dbg_state);
      else n_pass++;
      bus.flush = 1'b1;
      @(posedge clk); #1;
      bus.flush = 1'b0;
      n_checks++;
      if ({bus.done, bus.busy, bus.dbz, bus.hi, bus.lo} !== {3'b000, 32'h11112222, 32'h33334444}) $display("FAIL flush_fix: got done=%b busy=%b dbz=%b hi=%h lo=%h", bus.done, bus.busy, bus.dbz, bus.hi, bus.lo);
      else n_pass++;
   endtask

   task automatic test_reset_mid();
      int seen;
      bus.op = 3'd1; bus.a = 32'hCAFEF00D; bus.b = 32'h00010001; bus.start = 1'b1;
      @(posedge clk); #1;
      bus.start = 1'b0;
      repeat (10) begin @(posedge clk); #1; end
      reset = 1'b0;
      #1;
      n_checks++;
      if ({bus.hi, bus.lo, bus.busy, bus.dbg_state} !== '0) $display("FAIL reset_mid: got hi=%h lo=%h busy=%b state=%0d want 0", bus.hi, bus.lo, bus.busy, bus.dbg_state);
      else n_pass++;
      @(posedge clk); #1;
      reset = 1'b1;
      seen = 0;
      repeat (40) begin @(posedge clk); #1; if (bus.done || bus.busy) seen++; end
      n_checks++;
      if (seen !== 0) $display("FAIL reset_mid_quiet: got %0d active cycles want 0", seen);
      else n_pass++;
   endtask

   task automatic test_width8();
      logic [2:0] t_op[3];
      logic [7:0] t_a[3], t_b[3];
      logic [15:0] t_exp[3];
      int lat, bcnt;
      t_op  = '{3'd0, 3'd0, 3'd2};
      t_a   = '{8'h80, 8'hF9, 8'hF9};
      t_b   = '{8'h80, 8'h03, 8'h02};
      t_exp = '{16'h4000, 16'hFFEB, 16'hFFFD};
      for (int i = 0; i < 3; i++) begin
         bus8.op = t_op[i]; bus8.a = t_a[i]; bus8.b = t_b[i]; bus8.start = 1'b1;
         @(posedge clk); #1;
         bus8.start = 1'b0;
         lat = -1;
         bcnt = bus8.busy ? 1 : 0;
         for (int k = 1; k <= 20; k++) begin
            @(posedge clk); #1;
            if (bus8.done) begin lat = k; break; end
            if (bus8.busy) bcnt++;
         end
         n_checks++;
         if (lat !== 9 || bcnt !== 9) $display("FAIL w8_timing[%0d]: got latency=%0d busy=%0d want 9 9", i, lat, bcnt);
         else n_pass++;
         n_checks++;
         if ({bus8.hi, bus8.lo} !== t_exp[i]) $display("FAIL w8_result[%0d]: got %h want %h", i, {bus8.hi, bus8.lo}, t_exp[i]);
         else n_pass++;
      end
   endtask

   task automatic test_back_to_back();
      logic [2*W:0] exp;
      logic [2:0] op;
      logic [W-1:0] a, b;
      int lat, bcnt;
      for (int i = 0; i < 16; i++) begin
         op = 3'($urandom_range(0, 3));
         a  = $urandom;
         b  = ($urandom_range(0, 7) == 0) ? '0 : $urandom;
         if (i == 3) b = 32'd1;
         start_op(op, a, b);
         wait_done(40, lat, bcnt);
         exp = exp_q.pop_front();
         n_checks++;
         if (lat !== W + 1 || {bus.dbz, bus.hi, bus.lo} !== exp) $display("FAIL random[%0d] op=%0d a=%h b=%h: got lat=%0d %h want lat=%0d %h", i, op, a, b, lat, {bus.dbz, bus.hi, bus.lo}, W + 1, exp);
         else n_pass++;
      end
      n_checks++;
      if (exp_q.size() !== 0) $display("FAIL scoreboard_empty: got %0d left want 0", exp_q.size());
      else n_pass++;
   endtask

   initial begin
      test_reset();
      test_arith();
      test_mthi_mtlo();
      test_busy_ignore();
      test_flush();
      test_reset_mid();
      test_width8();
      test_back_to_back();
      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end
endmodule

// File: doc/muldiv_iter.md
Name: muldiv_iter

Overview:
- Parametrised iterative multiply/divide unit with its own HI/LO registers; next generation of the CPU's separate MUL/MULTU/DIV/DIVU blocks.
- One shared shift-add/shift-subtract datapath serves all four ops.
- Adds a start/busy/done handshake, flush, defined divide-by-zero result and MTHI/MTLO writes.
- Sits beside the ALU; busy gates PC/regfile enables in the core.

Parameters:
- WIDTH, 32, operand and HI/LO width; any value ≥4.
- CNT_W, $clog2(WIDTH)+1, iteration counter width.

Ports:
- clk  in  1  clock; all state updates on rising edge.
- reset  in  1  asynchronous, active-low; clears all state.
- start  in  1  request; sampled only when busy=0.
- op  in  3  0=MULT 1=MULTU 2=DIV 3=DIVU 4=MTHI 5=MTLO; 6,7=no-op.
- a  in  WIDTH  multiplicand / dividend / MTHI-MTLO data (rs).
- b  in  WIDTH  multiplier / divisor (rt).
- flush  in  1  abort in-flight op.
- busy  out  1  high whenever state≠IDLE.
- done  out  1  one-cycle pulse when HI/LO updated by a mul/div.
- dbz  out  1  last DIV/DIVU had b=0; held until next accepted mul/div start.
- hi  out  WIDTH  HI register.
- lo  out  WIDTH  LO register.

Behaviour:
- Reset (reset=0, async): state=IDLE, hi=lo=0, busy=done=dbz=0, counter=0.
- States: IDLE, RUN, FIX.
- IDLE
  - start with op 0–3: latch |a|,|b| (or raw values for unsigned ops), result signs, op; clear dbz; counter=WIDTH; go to RUN.
  - start with op 4: hi<=a at that edge. Op 5: lo<=a. No busy, no done, stay IDLE.
  - Op 6/7 ignored.
- RUN: one iteration per cycle, counter decrements; at counter==1, go to FIX.
  - MUL: shift-add over a 2·WIDTH accumulator.
  - DIV: restoring shift-subtract producing WIDTH-bit quotient and remainder.
- FIX:
  - Apply two's-complement sign fix, write hi/lo, done=1, go to IDLE.
  - busy is low in the same cycle done is high (registered).
- Latency: start edge E → done high after edge E+WIDTH+1; busy high for WIDTH+1 cycles.
- Results:
  - MULT/MULTU: {hi,lo} = full 2·WIDTH product (signed/unsigned).
  - DIV/DIVU: lo=quotient, hi=remainder.
  - Signed division truncates toward zero; remainder takes the sign of the dividend.
  - Signed MIN/−1: lo=MIN, hi=0, no flag.
- Divide by zero (b=0): run the normal latency; lo=all ones, hi=a (raw dividend); dbz=1 at done.
- Start while busy: ignored, including MTHI/MTLO. No queueing.
- flush
  - In RUN: IDLE next edge; hi/lo/dbz unchanged; no done.
  - In FIX: flush wins; no write, no done.
  - Flush with start in IDLE: start ignored.
- Reset mid-operation: immediate IDLE, hi=lo=0, no done.
- Operands are sampled only at accept; a/b may change during RUN without effect.

Test Plan:
- MULTU a=0xFFFFFFFF b=0xFFFFFFFF → done at edge E+33; hi=0xFFFFFFFE, lo=0x00000001; busy high for exactly 33 cycles.
- MULT a=−7 (0xFFFFFFF9) b=3 → hi=0xFFFFFFFF, lo=0xFFFFFFEB. DIV a=−7 b=2 → lo=0xFFFFFFFD, hi=0xFFFFFFFF. DIVU a=7 b=2 → lo=3, hi=1.
- DIV a=0x80000000 b=0xFFFFFFFF → lo=0x80000000, hi=0, dbz=0. DIVU a=0x1234 b=0 → lo=0xFFFFFFFF, hi=0x1234, dbz=1; next MULTU start clears dbz.
- MTHI a=0xA5A5A5A5 then MTLO a=0x5A5A5A5A on consecutive cycles → hi/lo updated after one edge each; busy and done stay 0.
- Start MULTU; on cycle 5 of RUN issue start DIVU plus MTHI and change a/b → ignored; result equals the original MULTU product.
- Start DIV, assert flush in cycle 10 → IDLE next edge, hi/lo retain prior values, no done.
- Repeat with reset pulled low mid-RUN → hi=lo=0 immediately, busy=0.
- WIDTH=8 instance: MULT 0x80×0x80 → hi=0x40, lo=0x00; done at E+9.
